// File: rtl/clap_sequence_detector.sv
// rtl/clap_sequence_detector.sv - clap detector with holdoff and multi-clap sequence counter (optional CLAP_HYST_EN hysteresis)
module clap_sequence_detector #(
    parameter int AMP_W           = 9,
    parameter int CLAP_AMP_THR    = 16,
    parameter int CLAP_AMP_REL    = 8,
    parameter int CLAP_REPEAT_MIN = 300_000,
    parameter int SEQ_WINDOW      = 3_000_000,
    parameter int MAX_CLAPS       = 3
) (
    input  logic                             M_CLK,
    input  logic                             rst_n_i,
    input  logic [AMP_W-1:0]                 amplitude_i,
    input  logic                             en_i,
    output logic                             clap_pulse_o,
    output logic                             seq_valid_o,
    output logic [$clog2(MAX_CLAPS+1)-1:0]   seq_count_o,
    output logic                             busy_o
);

    localparam int CW = $clog2(MAX_CLAPS + 1);
    localparam int HW = $clog2(CLAP_REPEAT_MIN + 1);
    localparam int GW = $clog2(SEQ_WINDOW + 1);

    localparam logic [AMP_W-1:0] CENTER    = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [AMP_W-1:0] THR       = AMP_W'(CLAP_AMP_THR);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(CLAP_REPEAT_MIN);
    localparam logic [GW-1:0]    GAP_MAX   = GW'(SEQ_WINDOW);
    localparam logic [CW-1:0]    COUNT_MAX = CW'(MAX_CLAPS);

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AMP_W-1:0] offset;
    logic             on_clap;
    logic             on_clap_d;
    logic             candidate;
    logic             accepted;
    logic [HW-1:0]    holdoff;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [GW-1:0]    gap;
    logic [GW-1:0]    gap_next;
    logic             report;

    // Distance of the sample from the zero level; fits AMP_W bits even for amplitude 0
    always_comb begin
        offset = '0;
        if (amplitude_i >= CENTER) begin
            offset = amplitude_i - CENTER;
        end else begin
            offset = CENTER - amplitude_i;
        end
    end

    // Registered loudness flag, with optional hysteresis between release and start levels
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            on_clap   <= 1'b0;
            on_clap_d <= 1'b0;
        end else begin
`ifdef CLAP_HYST_EN
            if (offset > THR) begin
                on_clap <= 1'b1;
            end else if (offset < AMP_W'(CLAP_AMP_REL)) begin
                on_clap <= 1'b0;
            end
`else
            on_clap <= (offset > THR);
`endif
            on_clap_d <= on_clap;
        end
    end

    assign candidate = on_clap && !on_clap_d;
    assign accepted  = candidate && en_i && (holdoff == HOLD_MAX);

    // Holdoff counter: restarts on each accepted clap, saturates so the next one is allowed; keeps running with en_i low
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            holdoff      <= HOLD_MAX;
            clap_pulse_o <= 1'b0;
        end else begin
            clap_pulse_o <= accepted;
            if (accepted) begin
                holdoff <= '0;
            end else if (holdoff != HOLD_MAX) begin
                holdoff <= holdoff + HW'(1);
            end
        end
    end

    // Sequence FSM next state: abort on disable, full count reports first, a clap beats window expiry
    always_comb begin
        state_next = state;
        count_next = count;
        gap_next   = gap;
        report     = 1'b0;
        case (state)
            IDLE: begin
                if (accepted) begin
                    state_next = COUNTING;
                    count_next = CW'(1);
                    gap_next   = '0;
                end
            end
            COUNTING: begin
                if (!en_i) begin
                    state_next = IDLE;
                    count_next = '0;
                    gap_next   = '0;
                end else if (count == COUNT_MAX) begin
                    report     = 1'b1;
                    state_next = IDLE;
                    count_next = '0;
                    gap_next   = '0;
                end else if (accepted) begin
                    count_next = count + CW'(1);
                    gap_next   = '0;
                end else if (gap == GAP_MAX) begin
                    report     = 1'b1;
                    state_next = IDLE;
                    count_next = '0;
                    gap_next   = '0;
                end else begin
                    gap_next = gap + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                gap_next   = '0;
            end
        endcase
    end

    // Sequence FSM registers and the held report outputs
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            count       <= '0;
            gap         <= '0;
            seq_valid_o <= 1'b0;
            seq_count_o <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            gap         <= gap_next;
            seq_valid_o <= report;
            if (report) begin
                seq_count_o <= count;
            end
        end
    end

    assign busy_o = (state == COUNTING);

endmodule

// File: tb/tb_clap_sequence_detector.sv
// tb/tb_clap_sequence_detector.sv - scoreboard bench for clap_sequence_detector
module tb_clap_sequence_detector;

    localparam int AMP_W = 9;
    localparam int CW    = 2;
    localparam int WIN   = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AMP_W-1:0] amp = 9'd256;
    logic             en = 1'b1;
    logic             clap_pulse;
    logic             seq_valid;
    logic [CW-1:0]    seq_count;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } evt_t;

    evt_t sb[$];

    clap_sequence_detector #(
        .AMP_W          (AMP_W),
        .CLAP_AMP_THR   (16),
        .CLAP_AMP_REL   (8),
        .CLAP_REPEAT_MIN(10),
        .SEQ_WINDOW     (WIN),
        .MAX_CLAPS      (3)
    ) dut (
        .M_CLK       (clk),
        .rst_n_i     (rst_n),
        .amplitude_i (amp),
        .en_i        (en),
        .clap_pulse_o(clap_pulse),
        .seq_valid_o (seq_valid),
        .seq_count_o (seq_count),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_evt(input int kind, input int c, input int cnt);
        evt_t e;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic take_evt(input int kind, input int cnt);
        evt_t e;
        chk(kind == 1 ? "seq_expected" : "clap_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(kind == 1 ? "evt_kind_seq" : "evt_kind_clap", kind, e.kind);
            chk(kind == 1 ? "seq_cycle" : "clap_cycle", cyc, e.cyc);
            if (kind == 1) chk("seq_count", cnt, e.cnt);
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (clap_pulse) take_evt(0, 0);
        if (seq_valid) take_evt(1, int'(seq_count));
    end

    task automatic wait_to(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic burst_at(input int v, input int n, input int t);
        wait_to(t);
        for (int i = 0; i < n; i++) begin
            amp = AMP_W'(v);
            @(negedge clk);
        end
        amp = 9'd256;
    endtask

    initial begin
        int t;

        repeat (3) @(negedge clk);
        chk("rst_clap_pulse", int'(clap_pulse), 0);
        chk("rst_seq_valid", int'(seq_valid), 0);
        chk("rst_seq_count", int'(seq_count), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // single clap, reported at window expiry
        t = cyc + 3;
        push_evt(0, t + 2, 0);
        push_evt(1, t + 2 + WIN + 1, 1);
        burst_at(280, 3, t);
        chk("s1_busy", int'(busy), 1);
        wait_to(t + 65);
        chk("s1_drained", sb.size(), 0);
        chk("s1_count_held", int'(seq_count), 1);
        chk("s1_idle", int'(busy), 0);

        // three claps: early report on reaching the maximum
        t = cyc + 15;
        push_evt(0, t + 2, 0);
        push_evt(0, t + 22, 0);
        push_evt(0, t + 42, 0);
        push_evt(1, t + 43, 3);
        burst_at(230, 3, t);
        burst_at(230, 3, t + 20);
        wait_to(t + 30);
        chk("s2_busy_mid", int'(busy), 1);
        burst_at(230, 3, t + 40);
        wait_to(t + 44);
        chk("s2_busy_after", int'(busy), 0);
        chk("s2_count", int'(seq_count), 3);
        chk("s2_drained", sb.size(), 0);

        // second burst inside holdoff is ignored
        t = cyc + 15;
        push_evt(0, t + 2, 0);
        push_evt(1, t + 2 + WIN + 1, 1);
        burst_at(280, 2, t);
        burst_at(280, 2, t + 5);
        wait_to(t + 65);
        chk("s3_drained", sb.size(), 0);
        chk("s3_count", int'(seq_count), 1);

        // 280,268,280: one clap whether or not hysteresis is built in
        t = cyc + 15;
        push_evt(0, t + 2, 0);
        push_evt(1, t + 2 + WIN + 1, 1);
        wait_to(t);
        amp = 9'd280;
        @(negedge clk);
        amp = 9'd268;
        @(negedge clk);
        amp = 9'd280;
        @(negedge clk);
        amp = 9'd256;
        wait_to(t + 65);
        chk("s4_drained", sb.size(), 0);

        // reset mid-sequence discards it
        t = cyc + 15;
        push_evt(0, t + 2, 0);
        push_evt(0, t + 22, 0);
        burst_at(280, 3, t);
        burst_at(280, 3, t + 20);
        wait_to(t + 42);
        chk("s5_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s5_busy", int'(busy), 0);
        chk("s5_count", int'(seq_count), 0);
        wait_to(t + 120);
        chk("s5_drained", sb.size(), 0);

        // disable mid-sequence aborts, and no claps while disabled
        t = cyc + 15;
        push_evt(0, t + 2, 0);
        burst_at(280, 3, t);
        wait_to(t + 10);
        chk("s6_busy_before", int'(busy), 1);
        en = 1'b0;
        @(negedge clk);
        chk("s6_busy_abort", int'(busy), 0);
        burst_at(280, 3, t + 15);
        wait_to(t + 30);
        en = 1'b1;
        wait_to(t + 100);
        chk("s6_drained", sb.size(), 0);
        chk("s6_count", int'(seq_count), 0);
        chk("s6_busy_end", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
